sfp_stream_framer: RTL and testbench



---
 rtl/sfp_stream_framer.sv | 156 +++++++++++++++
 tb/tb_sfp_stream_framer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_stream_framer.sv
// sfp_stream_framer: serialises parallel TX frames into AXI-Stream beats and reassembles RX beats into frames.
// Define SFP_FRAMER_SEQ_EN to add a {16'hA55A, seq} header beat on TX and a magic check on RX.
module sfp_stream_framer #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_DATA_STREAM_BIT  = 128
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [C_DATA_STREAM_BIT-1:0]  i_tx_stream_data,
  input  logic                          i_sfp_start_flag,
  output logic [C_DATA_STREAM_BIT-1:0]  o_rx_stream_data,
  output logic                          o_sfp_end_flag,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          o_tx_busy,
  output logic                          o_rx_err,
  output logic [15:0]                   o_rx_err_cnt
);
  localparam int W = C_AXIS_TDATA_WIDTH;
  localparam int C = C_DATA_STREAM_BIT;
  localparam int N = C / W;
`ifdef SFP_FRAMER_SEQ_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BEATS    = N + HDR;
  localparam int RXF_W    = C - W;
  localparam int TX_CNT_W = $clog2(BEATS);
  localparam int RX_CNT_W = $clog2(BEATS + 1);
  localparam logic [TX_CNT_W-1:0] TX_LAST   = TX_CNT_W'(BEATS - 1);
  localparam logic [TX_CNT_W-1:0] TX_PENULT = TX_CNT_W'(BEATS - 2);
  localparam logic [RX_CNT_W-1:0] RX_LAST   = RX_CNT_W'(BEATS - 1);
  localparam logic [RX_CNT_W-1:0] RX_FULL   = RX_CNT_W'(BEATS);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_DROP} rx_state_t;

  tx_state_t           tx_state;
  logic [TX_CNT_W-1:0] tx_cnt;
  logic [C-1:0]        tx_shift;
  logic [C-1:0]        tx_load;
  logic [W-1:0]        tx_first_beat;
  logic                tx_adv, tx_done, tx_start;

  rx_state_t           rx_state;
  logic [RX_CNT_W-1:0] rx_cnt;
  logic [RXF_W-1:0]    rx_frame;
  logic                rx_bad_hdr, rx_data_beat, rx_overrun, rx_discard;

  // A start is accepted when idle or on the final handshake, giving gapless back-to-back frames.
  assign tx_adv    = (tx_state == TX_SEND) && m_axis_tready;
  assign tx_done   = tx_adv && (tx_cnt == TX_LAST);
  assign tx_start  = i_sfp_start_flag && ((tx_state == TX_IDLE) || tx_done);
  assign o_tx_busy = (tx_state == TX_SEND);

`ifdef SFP_FRAMER_SEQ_EN
  logic [15:0] tx_seq, tx_seq_cur;
  assign tx_seq_cur    = tx_done ? tx_seq + 16'd1 : tx_seq;
  assign tx_first_beat = W'({16'hA55A, tx_seq_cur});
  assign tx_load       = i_tx_stream_data;
  assign rx_bad_hdr    = (rx_cnt == '0) && (s_axis_tdata[31:16] != 16'hA55A);
  assign rx_data_beat  = (rx_cnt != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        tx_seq <= 16'd0;
    else if (tx_done) tx_seq <= tx_seq + 16'd1;
  end
`else
  assign tx_first_beat = i_tx_stream_data[W-1:0];
  assign tx_load       = i_tx_stream_data >> W;
  assign rx_bad_hdr    = 1'b0;
  assign rx_data_beat  = 1'b1;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (tx_start) begin
      tx_state      <= TX_SEND;
      tx_cnt        <= '0;
      m_axis_tdata  <= tx_first_beat;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= 1'b0;
    end else if (tx_done) begin
      tx_state      <= TX_IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (tx_adv) begin
      tx_cnt        <= tx_cnt + TX_CNT_W'(1);
      m_axis_tdata  <= tx_shift[W-1:0];
      m_axis_tlast  <= (tx_cnt == TX_PENULT);
    end
  end

  // NOTE: payload shift registers carry no reset; they are always reloaded before their contents are used.
  always_ff @(posedge i_clk) begin
    if (tx_start)    tx_shift <= tx_load;
    else if (tx_adv) tx_shift <= tx_shift >> W;
  end

  // Beats shift in from the top, so the final beat completes the frame LSB-first.
  always_ff @(posedge i_clk) begin
    if (s_axis_tvalid && (rx_state != RX_DROP) && rx_data_beat && !rx_overrun)
      rx_frame <= RXF_W'({s_axis_tdata, rx_frame} >> W);
  end

  assign rx_overrun = (rx_cnt == RX_FULL);
  assign rx_discard = rx_overrun || rx_bad_hdr || (s_axis_tlast && (rx_cnt != RX_LAST));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state         <= RX_IDLE;
      rx_cnt           <= '0;
      o_rx_stream_data <= '0;
      o_sfp_end_flag   <= 1'b0;
      o_rx_err         <= 1'b0;
      o_rx_err_cnt     <= 16'd0;
    end else begin
      o_sfp_end_flag <= 1'b0;
      o_rx_err       <= 1'b0;
      if (s_axis_tvalid) begin
        if (rx_state == RX_DROP) begin
          if (s_axis_tlast) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
          end
        end else if (rx_discard) begin
          o_rx_err <= 1'b1;
          if (o_rx_err_cnt != 16'hFFFF) o_rx_err_cnt <= o_rx_err_cnt + 16'd1;
          rx_cnt   <= '0;
          rx_state <= s_axis_tlast ? RX_IDLE : RX_DROP;
        end else if (s_axis_tlast) begin
          o_rx_stream_data <= {s_axis_tdata, rx_frame};
          o_sfp_end_flag   <= 1'b1;
          rx_cnt           <= '0;
          rx_state         <= RX_IDLE;
        end else begin
          rx_cnt   <= rx_cnt + RX_CNT_W'(1);
          rx_state <= RX_COLLECT;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfp_stream_framer.sv
// Directed testbench for sfp_stream_framer at default parameters (N = 4, no header beat).
module tb_sfp_stream_framer;
  localparam int W = 32;
  localparam int C = 128;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [C-1:0]  i_tx_stream_data;
  logic          i_sfp_start_flag;
  logic [C-1:0]  o_rx_stream_data;
  logic          o_sfp_end_flag;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast;
  logic          o_tx_busy, o_rx_err;
  logic [15:0]   o_rx_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  sfp_stream_framer #(.C_AXIS_TDATA_WIDTH(W), .C_DATA_STREAM_BIT(C)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_tx_stream_data(i_tx_stream_data), .i_sfp_start_flag(i_sfp_start_flag),
    .o_rx_stream_data(o_rx_stream_data), .o_sfp_end_flag(o_sfp_end_flag),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .o_tx_busy(o_tx_busy), .o_rx_err(o_rx_err), .o_rx_err_cnt(o_rx_err_cnt)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic rx_beat(input logic [W-1:0] data, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_tx_stream_data = '0; i_sfp_start_flag = 1'b0; m_axis_tready = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick(); tick();
    checks++;
    if ({o_rx_stream_data, o_sfp_end_flag, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
         o_tx_busy, o_rx_err, o_rx_err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got tvalid=%b busy=%b tdata=%h cnt=%h rx=%h expected all zero",
               m_axis_tvalid, o_tx_busy, m_axis_tdata, o_rx_err_cnt, o_rx_stream_data);
    end
    i_rst = 1'b0;
    tick();
    checks++;
    if ({m_axis_tvalid, o_tx_busy, o_sfp_end_flag, o_rx_err} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got %b expected 0000", {m_axis_tvalid, o_tx_busy, o_sfp_end_flag, o_rx_err});
    end
  endtask

  task automatic test_tx_basic();
    logic [W-1:0] exp_beats [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    i_tx_stream_data = 128'h44444444_33333333_22222222_11111111;
    m_axis_tready    = 1'b1;
    i_sfp_start_flag = 1'b1;
    tick();
    i_sfp_start_flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, o_tx_busy, m_axis_tdata} !== {1'b1, (k == 3), 1'b1, exp_beats[k]}) begin
        errors++;
        $display("FAIL tx_basic beat%0d got v/l/b/d=%b%b%b %h expected %b%b%b %h", k,
                 m_axis_tvalid, m_axis_tlast, o_tx_busy, m_axis_tdata, 1'b1, (k == 3), 1'b1, exp_beats[k]);
      end
      tick();
    end
    checks++;
    if ({m_axis_tvalid, o_tx_busy} !== 2'b00) begin
      errors++;
      $display("FAIL tx_basic_end got tvalid/busy=%b expected 00", {m_axis_tvalid, o_tx_busy});
    end
  endtask

  task automatic test_tx_backpressure();
    logic [W-1:0] exp_beats [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    int idx;
    i_tx_stream_data = 128'h44444444_33333333_22222222_11111111;
    i_sfp_start_flag = 1'b1;
    tick();
    for (int c = 0; c < 7; c++) begin
      m_axis_tready    = !(c >= 1 && c <= 3);
      i_sfp_start_flag = (c == 2);
      if (c == 2) i_tx_stream_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      idx = (c == 0) ? 0 : (c <= 4) ? 1 : c - 3;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, (idx == 3), exp_beats[idx]}) begin
        errors++;
        $display("FAIL tx_stall cycle%0d got v/l/d=%b%b %h expected %b%b %h", c,
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, 1'b1, (idx == 3), exp_beats[idx]);
      end
      tick();
    end
    i_sfp_start_flag = 1'b0;
    m_axis_tready    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({m_axis_tvalid, o_tx_busy} !== 2'b00) begin
        errors++;
        $display("FAIL tx_no_queued_frame cycle%0d got tvalid/busy=%b expected 00", c, {m_axis_tvalid, o_tx_busy});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_beats [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                     32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    i_tx_stream_data = 128'h44444444_33333333_22222222_11111111;
    i_sfp_start_flag = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      i_sfp_start_flag = (c == 3);
      if (c == 3) i_tx_stream_data = 128'h88888888_77777777_66666666_55555555;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, (c % 4 == 3), exp_beats[c]}) begin
        errors++;
        $display("FAIL back_to_back beat%0d got v/l/d=%b%b %h expected %b%b %h", c,
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, 1'b1, (c % 4 == 3), exp_beats[c]);
      end
      tick();
    end
    i_sfp_start_flag = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_end got tvalid=%b expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_rx_good();
    for (int i = 0; i < 4; i++) begin
      rx_beat(32'hAAAA0000 + W'(i), (i == 3));
      if (i < 3) begin
        checks++;
        if ({o_sfp_end_flag, o_rx_err} !== 2'b00) begin
          errors++;
          $display("FAIL rx_good_mid beat%0d got end/err=%b expected 00", i, {o_sfp_end_flag, o_rx_err});
        end
      end
    end
    checks++;
    if ({o_sfp_end_flag, o_rx_err, o_rx_stream_data} !== {2'b10, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000}) begin
      errors++;
      $display("FAIL rx_good got end/err=%b data=%h expected 10 %h", {o_sfp_end_flag, o_rx_err},
               o_rx_stream_data, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
    end
    tick();
    checks++;
    if ({o_sfp_end_flag, o_rx_stream_data} !== {1'b0, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000}) begin
      errors++;
      $display("FAIL rx_good_pulse got end=%b data=%h expected 0 and data held", o_sfp_end_flag, o_rx_stream_data);
    end
  endtask

  task automatic test_rx_short();
    for (int i = 0; i < 3; i++) rx_beat(32'hBBBB0000 + W'(i), (i == 2));
    checks++;
    if ({o_sfp_end_flag, o_rx_err, o_rx_err_cnt, o_rx_stream_data} !==
        {2'b01, 16'd1, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000}) begin
      errors++;
      $display("FAIL rx_short got end/err=%b cnt=%0d data=%h expected 01 cnt=1 old data",
               {o_sfp_end_flag, o_rx_err}, o_rx_err_cnt, o_rx_stream_data);
    end
    tick();
    checks++;
    if (o_rx_err !== 1'b0) begin
      errors++;
      $display("FAIL rx_short_pulse got err=%b expected 0", o_rx_err);
    end
    for (int i = 0; i < 4; i++) rx_beat(32'hCCCC0000 + W'(i), (i == 3));
    checks++;
    if ({o_sfp_end_flag, o_rx_err_cnt, o_rx_stream_data} !== {1'b1, 16'd1, 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000}) begin
      errors++;
      $display("FAIL rx_after_short got end=%b cnt=%0d data=%h expected 1 cnt=1 CCCC frame",
               o_sfp_end_flag, o_rx_err_cnt, o_rx_stream_data);
    end
  endtask

  task automatic test_rx_long();
    for (int i = 0; i < 6; i++) begin
      rx_beat(32'hDDDD0000 + W'(i), (i == 5));
      checks++;
      if ({o_sfp_end_flag, o_rx_err} !== {1'b0, (i == 4)}) begin
        errors++;
        $display("FAIL rx_long beat%0d got end/err=%b expected 0%b", i, {o_sfp_end_flag, o_rx_err}, (i == 4));
      end
    end
    checks++;
    if ({o_rx_err_cnt, o_rx_stream_data} !== {16'd2, 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000}) begin
      errors++;
      $display("FAIL rx_long_cnt got cnt=%0d data=%h expected cnt=2 CCCC frame", o_rx_err_cnt, o_rx_stream_data);
    end
    for (int i = 0; i < 4; i++) rx_beat(32'hEEEE0000 + W'(i), (i == 3));
    checks++;
    if ({o_sfp_end_flag, o_rx_err, o_rx_stream_data} !== {2'b10, 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000}) begin
      errors++;
      $display("FAIL rx_after_long got end/err=%b data=%h expected 10 EEEE frame",
               {o_sfp_end_flag, o_rx_err}, o_rx_stream_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_beats [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    i_tx_stream_data = 128'h44444444_33333333_22222222_11111111;
    i_sfp_start_flag = 1'b1;
    tick();
    i_sfp_start_flag = 1'b0;
    tick();
    rx_beat(32'hFFFF0000, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hFFFF0001;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_rx_stream_data, o_sfp_end_flag, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
         o_tx_busy, o_rx_err, o_rx_err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid got tvalid=%b busy=%b tdata=%h cnt=%0d rx=%h expected all zero",
               m_axis_tvalid, o_tx_busy, m_axis_tdata, o_rx_err_cnt, o_rx_stream_data);
    end
    s_axis_tvalid = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
    i_sfp_start_flag = 1'b1;
    tick();
    i_sfp_start_flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, (k == 3), exp_beats[k]}) begin
        errors++;
        $display("FAIL reset_tx beat%0d got v/l/d=%b%b %h expected %b%b %h", k,
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, 1'b1, (k == 3), exp_beats[k]);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) rx_beat(32'h99990000 + W'(i), (i == 3));
    checks++;
    if ({o_sfp_end_flag, o_rx_err, o_rx_err_cnt, o_rx_stream_data} !==
        {2'b10, 16'd0, 128'h99990003_99990002_99990001_99990000}) begin
      errors++;
      $display("FAIL reset_rx got end/err=%b cnt=%0d data=%h expected 10 cnt=0 9999 frame",
               {o_sfp_end_flag, o_rx_err}, o_rx_err_cnt, o_rx_stream_data);
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_backpressure();
    test_back_to_back();
    test_rx_good();
    test_rx_short();
    test_rx_long();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
